// File: rtl/ldl_hist_drain_if.sv
// Event/drain bundle for ldl_hist_drain: event pulses and clear in, pending
// vector and a valid/ready index stream out.
interface ldl_hist_drain_if #(
   parameter int WIDTH = 8
);
   localparam int IDX_W = $clog2(WIDTH);

   logic             clr;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] pend;
   logic             o_valid;
   logic             o_ready;
   logic [IDX_W-1:0] o_idx;
   logic             o_merge;

   // master: event source plus index consumer; slave: the drain block
   modport master (
      output clr,
      output x,
      output o_ready,
      input  pend,
      input  o_valid,
      input  o_idx,
      input  o_merge
   );

   modport slave (
      input  clr,
      input  x,
      input  o_ready,
      output pend,
      output o_valid,
      output o_idx,
      output o_merge
   );
endinterface

// File: rtl/ldl_hist_drain.sv
// Sticky event history with a round-robin drain: events collect in a pending
// vector and leave one index per handshake, each bit cleared as it is handed out.
module ldl_hist_drain #(
   parameter int WIDTH = 8
) (
   input  logic          clk,
   input  logic          rst,
   ldl_hist_drain_if.slave bus
);
   localparam int IDX_W = $clog2(WIDTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

   logic [WIDTH-1:0] pend_q, pend_d;
   logic             valid_q, valid_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic             merge_q, merge_d;

   logic [WIDTH-1:0] hi_mask;
   logic [WIDTH-1:0] hi_pend;
   logic [WIDTH-1:0] load_mask;
   logic [IDX_W-1:0] sel_hi;
   logic [IDX_W-1:0] sel_any;
   logic [IDX_W-1:0] sel;
   logic             take;
   logic             load;

   assign take = valid_q & bus.o_ready;
   assign load = (|pend_q) & (~valid_q | bus.o_ready);

   // Bits at or above ptr are searched first; if none are pending the
   // lowest pending bit overall is the wrapped-around choice.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mask
         assign hi_mask[gi]   = (IDX_W'(gi) >= ptr_q);
         assign load_mask[gi] = load & (sel == IDX_W'(gi));
      end
   endgenerate

   assign hi_pend = pend_q & hi_mask;

   always_comb begin
      sel_hi  = '0;
      sel_any = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (hi_pend[i]) sel_hi = IDX_W'(i);
         if (pend_q[i])  sel_any = IDX_W'(i);
      end
      sel = (|hi_pend) ? sel_hi : sel_any;
   end

   always_comb begin
      pend_d  = pend_q;
      valid_d = valid_q;
      idx_d   = idx_q;
      ptr_d   = ptr_q;
      merge_d = merge_q;
      if (bus.clr) begin
         pend_d  = '0;
         valid_d = 1'b0;
         idx_d   = '0;
         ptr_d   = '0;
         merge_d = 1'b0;
      end else begin
         // A new pulse on the bit being loaded re-arms it without merging.
         pend_d  = (pend_q & ~load_mask) | bus.x;
         merge_d = merge_q | (|(bus.x & pend_q & ~load_mask));
         if (load) begin
            valid_d = 1'b1;
            idx_d   = sel;
            ptr_d   = (sel == LAST_IDX) ? '0 : sel + IDX_W'(1);
         end else if (take) begin
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q  <= '0;
         valid_q <= 1'b0;
         idx_q   <= '0;
         ptr_q   <= '0;
         merge_q <= 1'b0;
      end else begin
         pend_q  <= pend_d;
         valid_q <= valid_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
         merge_q <= merge_d;
      end
   end

   assign bus.pend    = pend_q;
   assign bus.o_valid = valid_q;
   assign bus.o_idx   = idx_q;
   assign bus.o_merge = merge_q;
endmodule

// File: tb/tb_ldl_hist_drain.sv
// Directed bench for ldl_hist_drain (WIDTH=8 and WIDTH=5) against a
// set-based reference model, plus literal grant-order expectations.
module tb_ldl_hist_drain;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   ldl_hist_drain_if #(.WIDTH(8)) a ();
   ldl_hist_drain_if #(.WIDTH(5)) b ();

   ldl_hist_drain #(.WIDTH(8)) u_a (.clk(clk), .rst(rst), .bus(a));
   ldl_hist_drain #(.WIDTH(5)) u_b (.clk(clk), .rst(rst), .bus(b));

   typedef struct packed {
      logic [255:0] pend;
      logic         valid;
      logic [8:0]   idx;
      logic [8:0]   ptr;
      logic         merge;
   } mstate_t;

   mstate_t ma, mb;
   int log_a[$];
   int log_b[$];

   // Model: pending is a set of indices; the offered slot is refilled with
   // the next pending index found walking circularly from ptr.
   function automatic mstate_t step(mstate_t s, int w, logic [255:0] xv, bit rdy, bit clr);
      mstate_t n;
      int      sel;
      bit      found;
      bit      load;
      n = s;
      if (clr) begin
         n = '0;
         return n;
      end
      load  = (s.pend != '0) && (!s.valid || rdy);
      sel   = 0;
      found = 0;
      for (int k = 0; k < w; k++) begin
         int j;
         j = (int'(s.ptr) + k) % w;
         if (!found && s.pend[j]) begin
            sel   = j;
            found = 1;
         end
      end
      for (int i = 0; i < w; i++) begin
         if (xv[i] && s.pend[i] && !(load && i == sel)) n.merge = 1'b1;
      end
      if (load) n.pend[sel] = 1'b0;
      for (int i = 0; i < w; i++) begin
         if (xv[i]) n.pend[i] = 1'b1;
      end
      if (load) begin
         n.valid = 1'b1;
         n.idx   = 9'(sel);
         n.ptr   = 9'((sel + 1) % w);
      end else if (s.valid && rdy) begin
         n.valid = 1'b0;
      end
      return n;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ma <= '0;
         mb <= '0;
      end else begin
         ma <= step(ma, 8, 256'(a.x), a.o_ready, a.clr);
         mb <= step(mb, 5, 256'(b.x), b.o_ready, b.clr);
      end
   end

   task automatic chk(string name, longint act, longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("a.pend",    longint'(a.pend),    longint'(ma.pend[7:0]));
      chk("a.o_valid", longint'(a.o_valid), longint'(ma.valid));
      chk("a.o_idx",   longint'(a.o_idx),   longint'(ma.idx));
      chk("a.o_merge", longint'(a.o_merge), longint'(ma.merge));
      chk("b.pend",    longint'(b.pend),    longint'(mb.pend[4:0]));
      chk("b.o_valid", longint'(b.o_valid), longint'(mb.valid));
      chk("b.o_idx",   longint'(b.o_idx),   longint'(mb.idx));
      chk("b.o_merge", longint'(b.o_merge), longint'(mb.merge));
      if (!rst && a.o_valid && a.o_ready && !a.clr) log_a.push_back(int'(a.o_idx));
      if (!rst && b.o_valid && b.o_ready && !b.clr) log_b.push_back(int'(b.o_idx));
   end

   task automatic cyc(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_a(logic [7:0] v);
      a.x = v;
      cyc(1);
      a.x = '0;
   endtask

   task automatic pulse_b(logic [4:0] v);
      b.x = v;
      cyc(1);
      b.x = '0;
   endtask

   task automatic clr_a();
      a.clr = 1'b1;
      cyc(1);
      a.clr = 1'b0;
      log_a.delete();
   endtask

   task automatic chk_log(string name, bit use_b, int n, int exp[8]);
      int got[$];
      got = use_b ? log_b : log_a;
      chk({name, ".count"}, longint'(got.size()), longint'(n));
      for (int i = 0; i < n && i < got.size(); i++) begin
         chk($sformatf("%s[%0d]", name, i), longint'(got[i]), longint'(exp[i]));
      end
      $display("grant log %s: %0d entries", name, got.size());
   endtask

   initial begin
      a.clr = 1'b0; a.x = '0; a.o_ready = 1'b0;
      b.clr = 1'b0; b.x = '0; b.o_ready = 1'b1;
      cyc(2);
      rst = 1'b0;
      cyc(1);

      // 1: asynchronous reset with live state, then a single event
      pulse_a(8'h0F);
      cyc(1);
      pulse_a(8'h01);
      chk("t1.pend_pre", longint'(a.pend), 64'h0F);
      chk("t1.valid_pre", longint'(a.o_valid), 1);
      #2 rst = 1'b1;
      #1;
      chk("t1.rst_pend", longint'(a.pend), 0);
      chk("t1.rst_valid", longint'(a.o_valid), 0);
      chk("t1.rst_idx", longint'(a.o_idx), 0);
      chk("t1.rst_merge", longint'(a.o_merge), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      a.o_ready = 1'b1;
      pulse_a(8'h20);
      chk("t1.pend_t1", longint'(a.pend), 64'h20);
      chk("t1.valid_t1", longint'(a.o_valid), 0);
      cyc(1);
      chk("t1.valid_t2", longint'(a.o_valid), 1);
      chk("t1.idx_t2", longint'(a.o_idx), 5);
      chk("t1.pend_t2", longint'(a.pend), 0);
      cyc(2);
      $display("test1 reset/single done");

      // 2: round-robin order, twice
      clr_a();
      pulse_a(8'h91);
      cyc(5);
      chk_log("t2a", 0, 3, '{0, 4, 7, 0, 0, 0, 0, 0});
      log_a.delete();
      pulse_a(8'h91);
      cyc(5);
      chk_log("t2b", 0, 3, '{0, 4, 7, 0, 0, 0, 0, 0});

      // 3: chattering bit 1 must not starve bit 6
      clr_a();
      for (int c = 0; c < 8; c++) begin
         a.x = (c == 3) ? 8'h42 : 8'h02;
         cyc(1);
      end
      a.x = '0;
      cyc(4);
      chk_log("t3", 0, 8, '{1, 1, 1, 6, 1, 1, 1, 1});

      // 4: backpressure holds the offer; re-pulse of a pending bit merges
      a.o_ready = 1'b0;
      clr_a();
      pulse_a(8'h06);
      cyc(1);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("t4.hold_valid%0d", i), longint'(a.o_valid), 1);
         chk($sformatf("t4.hold_idx%0d", i), longint'(a.o_idx), 1);
         a.x = (i == 1) ? 8'h04 : 8'h00;
         cyc(1);
      end
      chk("t4.merge", longint'(a.o_merge), 1);
      a.o_ready = 1'b1;
      cyc(4);
      chk_log("t4", 0, 2, '{1, 2, 0, 0, 0, 0, 0, 0});
      chk("t4.valid_end", longint'(a.o_valid), 0);

      // 5: event on bit 3 in the very cycle bit 3 loads
      clr_a();
      a.x = 8'h08;
      cyc(2);
      chk("t5.valid", longint'(a.o_valid), 1);
      chk("t5.idx", longint'(a.o_idx), 3);
      chk("t5.pend", longint'(a.pend), 64'h08);
      chk("t5.merge", longint'(a.o_merge), 0);
      a.x = '0;
      cyc(4);
      chk_log("t5", 0, 2, '{3, 3, 0, 0, 0, 0, 0, 0});
      chk("t5.merge_end", longint'(a.o_merge), 0);

      // 6: clr beats x, take and merge; ptr returns to 0
      a.o_ready = 1'b0;
      clr_a();
      pulse_a(8'h03);
      cyc(1);
      pulse_a(8'h02);
      chk("t6.merge_pre", longint'(a.o_merge), 1);
      a.x = 8'hFF;
      a.clr = 1'b1;
      a.o_ready = 1'b1;
      cyc(1);
      a.x = '0;
      a.clr = 1'b0;
      chk("t6.pend", longint'(a.pend), 0);
      chk("t6.valid", longint'(a.o_valid), 0);
      chk("t6.merge", longint'(a.o_merge), 0);
      log_a.delete();
      pulse_a(8'h81);
      cyc(4);
      chk_log("t6", 0, 2, '{0, 7, 0, 0, 0, 0, 0, 0});

      // 6b: WIDTH=5 wrap from ptr=3 gives 4 then 0
      log_b.delete();
      pulse_b(5'h04);
      cyc(3);
      pulse_b(5'h11);
      cyc(4);
      chk_log("t6w5", 1, 3, '{2, 4, 0, 0, 0, 0, 0, 0});

      cyc(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
